ddr_maint_sequencer: RTL and testbench

- Parametrised successor to the controller's top-level init sequencer.
- Brings up DFI and DRAM, then runs ZQ long calibration after init.
- In operation, owns periodic maintenance per rank: refresh with postponement credits, opportunistic refresh, and periodic ZQ short calibration.
- Sits between the config block, the DDR init engine, the command scheduler and the DFI command mux. Takes the command slot only after the scheduler acknowledges a hold.

---
 rtl/ddr_maint_sequencer_if.sv | 38 +++
 rtl/ddr_maint_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ddr_maint_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_maint_sequencer_if.sv
// rtl/ddr_maint_sequencer_if.sv - init, scheduler, DFI command and config signals of the maintenance sequencer
interface ddr_maint_sequencer_if #(
    parameter int RANKS = 1
);
    logic             dfi_init_start;
    logic             dfi_init_complete;
    logic             ddr_init_start;
    logic             ddr_init_done;
    logic             r_empty;
    logic             sched_hold;
    logic             sched_idle;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [RANKS-1:0] cmd_cs_n;
    logic             cmd_ras_n;
    logic             cmd_cas_n;
    logic             cmd_we_n;
    logic             cmd_a10;
    logic             ready;
    logic [3:0]       ref_pending;
    logic             ref_overrun;
    logic             cfg_ref_en;
    logic             cfg_zqcs_en;

    modport master (
        output dfi_init_start, ddr_init_start, sched_hold, cmd_valid, cmd_cs_n,
               cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10, ready, ref_pending, ref_overrun,
        input  dfi_init_complete, ddr_init_done, r_empty, sched_idle, cmd_ready,
               cfg_ref_en, cfg_zqcs_en
    );

    modport slave (
        input  dfi_init_start, ddr_init_start, sched_hold, cmd_valid, cmd_cs_n,
               cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10, ready, ref_pending, ref_overrun,
        output dfi_init_complete, ddr_init_done, r_empty, sched_idle, cmd_ready,
               cfg_ref_en, cfg_zqcs_en
    );
endinterface

// File: rtl/ddr_maint_sequencer.sv
// rtl/ddr_maint_sequencer.sv - DFI/DRAM bring-up, ZQCL, then per-rank refresh and periodic ZQCS maintenance
module ddr_maint_sequencer #(
    parameter int RANKS        = 1,
    parameter int T_REFI       = 3120,
    parameter int T_RFC        = 88,
    parameter int T_RP         = 6,
    parameter int T_ZQINIT     = 512,
    parameter int T_ZQCS       = 64,
    parameter int ZQCS_EVERY   = 128,
    parameter int POSTPONE_MAX = 8
) (
    input  logic                   i_core_clk,
    input  logic                   i_core_arstn,
    ddr_maint_sequencer_if.master  io_maint
);
    localparam int         TW    = 16;
    localparam logic [3:0] P_MAX = 4'(POSTPONE_MAX);

    typedef enum logic [3:0] {
        S_RESET, S_INIT_DFI, S_INIT_DDR, S_ZQCL, S_IDLE, S_HOLD, S_PREA, S_REF, S_ZQCS
    } state_t;

    state_t           r_state;
    logic             r_dfi_init_start, r_ddr_init_start, r_sched_hold, r_ready;
    logic             r_cmd_valid, r_ras_n, r_cas_n, r_we_n, r_a10;
    logic [RANKS-1:0] r_cmd_cs_n;
    logic             r_op_zq, r_wait;
    logic [TW-1:0]    r_wait_cnt, r_refi_cnt, r_round;
    logic [3:0]       r_ref_pending;
    logic             r_ref_overrun, r_zq_due;

    logic [TW-1:0]    w_wait_lim;
    logic             w_in_loop, w_refi_wrap, w_wait_done, w_accept;
    logic             w_ref_done, w_zqcs_done, w_ref_due, w_zq_en;

    always_comb begin
        w_wait_lim = '0;
        case (r_state)
            S_ZQCL:  w_wait_lim = TW'(T_ZQINIT);
            S_PREA:  w_wait_lim = TW'(T_RP);
            S_REF:   w_wait_lim = TW'(T_RFC);
            S_ZQCS:  w_wait_lim = TW'(T_ZQCS);
            default: w_wait_lim = '0;
        endcase
    end

    assign w_in_loop   = (r_state == S_IDLE) || (r_state == S_HOLD) || (r_state == S_PREA) ||
                         (r_state == S_REF)  || (r_state == S_ZQCS);
    assign w_refi_wrap = w_in_loop && io_maint.cfg_ref_en && (r_refi_cnt == TW'(T_REFI - 1));
    assign w_wait_done = r_wait && (r_wait_cnt == w_wait_lim);
    assign w_accept    = r_cmd_valid && io_maint.cmd_ready;
    assign w_ref_done  = (r_state == S_REF) && w_wait_done;
    assign w_zqcs_done = (r_state == S_ZQCS) && w_wait_done;
    assign w_zq_en     = io_maint.cfg_zqcs_en && (ZQCS_EVERY > 0);
    assign w_ref_due   = io_maint.cfg_ref_en &&
                         ((r_ref_pending == P_MAX) || ((r_ref_pending != 4'd0) && io_maint.r_empty));

    // Interval timer restarts from zero whenever refresh is disabled or the loop is left.
    always_ff @(posedge i_core_clk or negedge i_core_arstn) begin
        if (!i_core_arstn) begin
            r_refi_cnt    <= '0;
            r_ref_pending <= '0;
            r_ref_overrun <= 1'b0;
            r_round       <= '0;
            r_zq_due      <= 1'b0;
        end else begin
            if (w_in_loop && io_maint.cfg_ref_en)
                r_refi_cnt <= w_refi_wrap ? '0 : r_refi_cnt + 1'b1;
            else
                r_refi_cnt <= '0;

            if (w_refi_wrap && !w_ref_done) begin
                if (r_ref_pending == P_MAX) r_ref_overrun <= 1'b1;
                else                        r_ref_pending <= r_ref_pending + 1'b1;
            end else if (w_ref_done && !w_refi_wrap) begin
                r_ref_pending <= r_ref_pending - 1'b1;
            end

            if (w_zqcs_done) begin
                r_zq_due <= 1'b0;
            end else if (w_ref_done && w_zq_en) begin
                if (r_round == TW'(ZQCS_EVERY - 1)) begin
                    r_zq_due <= 1'b1;
                    r_round  <= '0;
                end else begin
                    r_round  <= r_round + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_core_clk or negedge i_core_arstn) begin
        if (!i_core_arstn) begin
            r_state          <= S_RESET;
            r_dfi_init_start <= 1'b0;
            r_ddr_init_start <= 1'b0;
            r_sched_hold     <= 1'b0;
            r_ready          <= 1'b0;
            r_cmd_valid      <= 1'b0;
            r_cmd_cs_n       <= '1;
            r_ras_n          <= 1'b1;
            r_cas_n          <= 1'b1;
            r_we_n           <= 1'b1;
            r_a10            <= 1'b0;
            r_op_zq          <= 1'b0;
            r_wait           <= 1'b0;
            r_wait_cnt       <= '0;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_INIT_DFI;
                S_INIT_DFI: begin
                    r_dfi_init_start <= 1'b1;
                    if (io_maint.dfi_init_complete) begin
                        r_state          <= S_INIT_DDR;
                        r_ddr_init_start <= 1'b1;
                    end
                end
                S_INIT_DDR: if (io_maint.ddr_init_done) begin
                    r_state          <= S_ZQCL;
                    r_dfi_init_start <= 1'b0;
                    r_ddr_init_start <= 1'b0;
                    r_cmd_valid      <= 1'b1;
                    r_cmd_cs_n       <= '0;
                    {r_ras_n, r_cas_n, r_we_n, r_a10} <= 4'b1101;
                end
                S_IDLE: begin
                    if (w_ref_due) begin
                        r_state      <= S_HOLD;
                        r_op_zq      <= 1'b0;
                        r_sched_hold <= 1'b1;
                    end else if (r_zq_due) begin
                        r_state      <= S_HOLD;
                        r_op_zq      <= 1'b1;
                        r_sched_hold <= 1'b1;
                    end
                end
                S_HOLD: if (io_maint.sched_idle) begin
                    r_state     <= S_PREA;
                    r_cmd_valid <= 1'b1;
                    r_cmd_cs_n  <= '0;
                    {r_ras_n, r_cas_n, r_we_n, r_a10} <= 4'b0101;
                end
                S_ZQCL, S_PREA, S_REF, S_ZQCS: begin
                    if (!r_wait) begin
                        if (w_accept) begin
                            r_cmd_valid <= 1'b0;
                            r_cmd_cs_n  <= '1;
                            {r_ras_n, r_cas_n, r_we_n, r_a10} <= 4'b1110;
                            r_wait      <= 1'b1;
                            r_wait_cnt  <= '0;
                        end
                    end else if (w_wait_done) begin
                        r_wait <= 1'b0;
                        case (r_state)
                            S_ZQCL: begin
                                r_state <= S_IDLE;
                                r_ready <= 1'b1;
                            end
                            S_PREA: begin
                                r_cmd_valid <= 1'b1;
                                r_cmd_cs_n  <= '0;
                                if (r_op_zq) begin
                                    r_state <= S_ZQCS;
                                    {r_ras_n, r_cas_n, r_we_n, r_a10} <= 4'b1100;
                                end else begin
                                    r_state <= S_REF;
                                    {r_ras_n, r_cas_n, r_we_n, r_a10} <= 4'b0010;
                                end
                            end
                            default: begin
                                r_state      <= S_IDLE;
                                r_sched_hold <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= S_RESET;
            endcase
        end
    end

    assign io_maint.dfi_init_start = r_dfi_init_start;
    assign io_maint.ddr_init_start = r_ddr_init_start;
    assign io_maint.sched_hold     = r_sched_hold;
    assign io_maint.cmd_valid      = r_cmd_valid;
    assign io_maint.cmd_cs_n       = r_cmd_cs_n;
    assign io_maint.cmd_ras_n      = r_ras_n;
    assign io_maint.cmd_cas_n      = r_cas_n;
    assign io_maint.cmd_we_n       = r_we_n;
    assign io_maint.cmd_a10        = r_a10;
    assign io_maint.ready          = r_ready;
    assign io_maint.ref_pending    = r_ref_pending;
    assign io_maint.ref_overrun    = r_ref_overrun;
endmodule

// File: tb/tb_ddr_maint_sequencer.sv
// tb/tb_ddr_maint_sequencer.sv - directed bench for bring-up, refresh, postponement, overrun, ZQCS and reset abort
module tb_ddr_maint_sequencer;
    localparam int RANKS = 2, T_REFI = 100, T_RFC = 8, T_RP = 3, T_ZQINIT = 20, T_ZQCS = 5;
    localparam int ZQCS_EVERY = 2, POSTPONE_MAX = 8;

    // {cs_n[1:0], ras_n, cas_n, we_n}
    localparam logic [4:0] C_PREA = 5'b00010;
    localparam logic [4:0] C_REF  = 5'b00001;
    localparam logic [4:0] C_ZQ   = 5'b00110;
    // {dfi_start, ddr_start, hold, valid, cs_n, ras, cas, we, a10, ready, pending, overrun}
    localparam logic [15:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};

    logic clk = 1'b0;
    logic arstn = 1'b0;
    int n_checks = 0;
    int n_fails = 0;
    int ev_dfi, ev_ddr, ev_zqcl, ev_ready, n_valid;
    logic [4:0] zqcl_code;
    logic zqcl_a10;
    logic [4:0] log_code[$];
    logic log_a10[$];
    int log_cyc[$];

    always #5 clk = ~clk;

    ddr_maint_sequencer_if #(.RANKS(RANKS)) bus ();

    ddr_maint_sequencer #(
        .RANKS(RANKS), .T_REFI(T_REFI), .T_RFC(T_RFC), .T_RP(T_RP), .T_ZQINIT(T_ZQINIT),
        .T_ZQCS(T_ZQCS), .ZQCS_EVERY(ZQCS_EVERY), .POSTPONE_MAX(POSTPONE_MAX)
    ) dut (
        .i_core_clk  (clk),
        .i_core_arstn(arstn),
        .io_maint    (bus)
    );

    function automatic logic [15:0] out_vec();
        return {bus.dfi_init_start, bus.ddr_init_start, bus.sched_hold, bus.cmd_valid, bus.cmd_cs_n,
                bus.cmd_ras_n, bus.cmd_cas_n, bus.cmd_we_n, bus.cmd_a10, bus.ready,
                bus.ref_pending, bus.ref_overrun};
    endfunction

    function automatic logic [4:0] cmd_code();
        return {bus.cmd_cs_n, bus.cmd_ras_n, bus.cmd_cas_n, bus.cmd_we_n};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_cmd(input int c);
        if (bus.cmd_valid) begin
            log_code.push_back(cmd_code());
            log_a10.push_back(bus.cmd_a10);
            log_cyc.push_back(c);
        end
    endtask

    task automatic set_defaults();
        bus.dfi_init_complete = 1'b0;
        bus.ddr_init_done     = 1'b0;
        bus.cmd_ready         = 1'b1;
        bus.sched_idle        = 1'b1;
        bus.r_empty           = 1'b1;
        bus.cfg_ref_en        = 1'b0;
        bus.cfg_zqcs_en       = 1'b0;
    endtask

    // Fixed 80-cycle bring-up: PHY done at cycle 10, DRAM done at cycle 50.
    task automatic bring_up();
        arstn = 1'b0;
        set_defaults();
        repeat (3) tick();
        arstn = 1'b1;
        ev_dfi = 0; ev_ddr = 0; ev_zqcl = 0; ev_ready = 0; n_valid = 0;
        zqcl_code = '1; zqcl_a10 = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (bus.dfi_init_start && ev_dfi == 0) ev_dfi = c;
            if (bus.ddr_init_start && ev_ddr == 0) ev_ddr = c;
            if (bus.cmd_valid) begin
                n_valid++;
                if (ev_zqcl == 0) begin
                    ev_zqcl = c;
                    zqcl_code = cmd_code();
                    zqcl_a10 = bus.cmd_a10;
                end
            end
            if (bus.ready && ev_ready == 0) ev_ready = c;
            if (c == 10) bus.dfi_init_complete = 1'b1;
            if (c == 50) bus.ddr_init_done = 1'b1;
        end
    endtask

    task automatic test_reset();
        set_defaults();
        arstn = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (out_vec() !== RST_VEC) begin
            n_fails++;
            $display("FAIL reset_values: got %b want %b", out_vec(), RST_VEC);
        end
        repeat (5) tick();
        n_checks++;
        if (out_vec() !== RST_VEC) begin
            n_fails++;
            $display("FAIL reset_held: got %b want %b", out_vec(), RST_VEC);
        end
    endtask

    task automatic test_bringup();
        bring_up();
        n_checks++;
        if (ev_dfi != 2) begin n_fails++; $display("FAIL dfi_init_start_cycle: got %0d want 2", ev_dfi); end
        n_checks++;
        if (ev_ddr != 11) begin n_fails++; $display("FAIL ddr_init_start_cycle: got %0d want 11", ev_ddr); end
        n_checks++;
        if (ev_zqcl != 51) begin n_fails++; $display("FAIL zqcl_valid_cycle: got %0d want 51", ev_zqcl); end
        n_checks++;
        if (zqcl_code !== C_ZQ || zqcl_a10 !== 1'b1) begin
            n_fails++;
            $display("FAIL zqcl_encoding: got %b a10=%b want %b a10=1", zqcl_code, zqcl_a10, C_ZQ);
        end
        n_checks++;
        if (n_valid != 1) begin n_fails++; $display("FAIL zqcl_valid_cycles: got %0d want 1", n_valid); end
        n_checks++;
        if (ev_ready != 52 + T_ZQINIT + 1) begin
            n_fails++;
            $display("FAIL ready_cycle: got %0d want %0d", ev_ready, 52 + T_ZQINIT + 1);
        end
    endtask

    task automatic test_opp_refresh();
        int hold_rise, hold_fall;
        logic prev_hold;
        int exp_cyc[4] = '{102, 107, 202, 207};
        logic [4:0] exp_code[4] = '{C_PREA, C_REF, C_PREA, C_REF};
        hold_rise = 0; hold_fall = 0; prev_hold = 1'b0;
        log_code.delete(); log_a10.delete(); log_cyc.delete();
        bus.cfg_ref_en = 1'b1;
        for (int c = 1; c <= 250; c++) begin
            tick();
            sample_cmd(c);
            if (bus.sched_hold && !prev_hold && hold_rise == 0) hold_rise = c;
            if (!bus.sched_hold && prev_hold && hold_fall == 0) begin
                hold_fall = c;
                n_checks++;
                if (bus.ref_pending !== 4'd0) begin
                    n_fails++;
                    $display("FAIL opp_pending_after_ref: got %0d want 0", bus.ref_pending);
                end
            end
            prev_hold = bus.sched_hold;
            if (c == 100) begin
                n_checks++;
                if (bus.ref_pending !== 4'd1) begin
                    n_fails++;
                    $display("FAIL opp_pending_wrap: got %0d want 1", bus.ref_pending);
                end
            end
        end
        n_checks++;
        if (hold_rise != 101 || hold_fall != 117) begin
            n_fails++;
            $display("FAIL opp_hold_window: got %0d..%0d want 101..117", hold_rise, hold_fall);
        end
        for (int i = 0; i < 4; i++) begin
            logic [4:0] g_code;
            int g_cyc;
            g_code = (i < log_cyc.size()) ? log_code[i] : 5'h1f;
            g_cyc  = (i < log_cyc.size()) ? log_cyc[i] : -1;
            n_checks++;
            if (g_code !== exp_code[i] || g_cyc != exp_cyc[i]) begin
                n_fails++;
                $display("FAIL opp_cmd[%0d]: got %b@%0d want %b@%0d", i, g_code, g_cyc, exp_code[i], exp_cyc[i]);
            end
        end
        n_checks++;
        if (log_cyc.size() != 4 || log_a10[0] !== 1'b1) begin
            n_fails++;
            $display("FAIL opp_cmd_count: got %0d want 4", log_cyc.size());
        end
    endtask

    task automatic test_postpone_overrun();
        bus.cfg_ref_en = 1'b0;
        bus.sched_idle = 1'b0;
        bus.r_empty    = 1'b0;
        tick();
        bus.cfg_ref_en = 1'b1;
        for (int c = 1; c <= 916; c++) begin
            tick();
            if (c % 100 == 0 && c <= 800) begin
                n_checks++;
                if (bus.ref_pending !== 4'(c / 100)) begin
                    n_fails++;
                    $display("FAIL postpone_pending@%0d: got %0d want %0d", c, bus.ref_pending, c / 100);
                end
            end
            if (c == 800 || c == 801) begin
                n_checks++;
                if (bus.sched_hold !== (c == 801)) begin
                    n_fails++;
                    $display("FAIL forced_hold@%0d: got %b want %b", c, bus.sched_hold, c == 801);
                end
            end
            if (c == 899) begin
                n_checks++;
                if ({bus.sched_hold, bus.cmd_valid, bus.ref_overrun, bus.ref_pending} !== {3'b100, 4'd8}) begin
                    n_fails++;
                    $display("FAIL hold_wait: got hold=%b valid=%b ovr=%b pend=%0d want 1 0 0 8",
                             bus.sched_hold, bus.cmd_valid, bus.ref_overrun, bus.ref_pending);
                end
            end
            if (c == 900) begin
                n_checks++;
                if (bus.ref_overrun !== 1'b1 || bus.ref_pending !== 4'd8) begin
                    n_fails++;
                    $display("FAIL overrun: got ovr=%b pend=%0d want 1 8", bus.ref_overrun, bus.ref_pending);
                end
                bus.sched_idle = 1'b1;
            end
            if (c == 901 || c == 906) begin
                n_checks++;
                if (bus.cmd_valid !== 1'b1 || cmd_code() !== ((c == 901) ? C_PREA : C_REF)) begin
                    n_fails++;
                    $display("FAIL forced_cmd@%0d: got valid=%b code=%b want 1 %b", c, bus.cmd_valid,
                             cmd_code(), (c == 901) ? C_PREA : C_REF);
                end
            end
            if (c == 916) begin
                n_checks++;
                if (bus.ref_pending !== 4'd7 || bus.sched_hold !== 1'b0) begin
                    n_fails++;
                    $display("FAIL forced_done: got pend=%0d hold=%b want 7 0", bus.ref_pending, bus.sched_hold);
                end
            end
        end
    endtask

    task automatic test_zqcs_interleave();
        int exp_cyc[14] = '{102, 107, 202, 207, 219, 224, 507, 512, 524, 529, 541, 546, 558, 563};
        logic [4:0] exp_code[14] = '{C_PREA, C_REF, C_PREA, C_REF, C_PREA, C_ZQ, C_PREA, C_REF,
                                     C_PREA, C_REF, C_PREA, C_REF, C_PREA, C_ZQ};
        bring_up();
        n_checks++;
        if (bus.ready !== 1'b1) begin n_fails++; $display("FAIL zq_ready: got %b want 1", bus.ready); end
        log_code.delete(); log_a10.delete(); log_cyc.delete();
        bus.cfg_zqcs_en = 1'b1;
        bus.cfg_ref_en  = 1'b1;
        for (int c = 1; c <= 590; c++) begin
            tick();
            sample_cmd(c);
            if (c == 240) bus.r_empty = 1'b0;
            if (c == 505) bus.r_empty = 1'b1;
        end
        n_checks++;
        if (log_cyc.size() != 14) begin
            n_fails++;
            $display("FAIL zq_cmd_count: got %0d want 14", log_cyc.size());
        end
        for (int i = 0; i < 14; i++) begin
            logic [4:0] g_code;
            logic g_a10;
            int g_cyc;
            g_code = (i < log_cyc.size()) ? log_code[i] : 5'h1f;
            g_a10  = (i < log_cyc.size()) ? log_a10[i] : 1'bx;
            g_cyc  = (i < log_cyc.size()) ? log_cyc[i] : -1;
            n_checks++;
            if (g_code !== exp_code[i] || g_cyc != exp_cyc[i] ||
                (exp_code[i] != C_REF && g_a10 !== (exp_code[i] == C_PREA))) begin
                n_fails++;
                $display("FAIL zq_cmd[%0d]: got %b a10=%b @%0d want %b a10=%b @%0d", i, g_code, g_a10,
                         g_cyc, exp_code[i], exp_code[i] == C_PREA, exp_cyc[i]);
            end
        end
    endtask

    task automatic test_reset_mid_ref();
        int found;
        found = 0;
        for (int c = 1; c <= 200 && found == 0; c++) begin
            tick();
            if (bus.cmd_valid && cmd_code() == C_REF) begin
                bus.cmd_ready = 1'b0;
                found = c;
            end
        end
        n_checks++;
        if (found == 0) begin n_fails++; $display("FAIL mid_ref_wait: got timeout want REF command"); end
        repeat (3) tick();
        n_checks++;
        if (bus.cmd_valid !== 1'b1 || cmd_code() !== C_REF) begin
            n_fails++;
            $display("FAIL ref_held: got valid=%b code=%b want 1 %b", bus.cmd_valid, cmd_code(), C_REF);
        end
        #2 arstn = 1'b0;
        #1;
        n_checks++;
        if (out_vec() !== RST_VEC) begin
            n_fails++;
            $display("FAIL async_reset: got %b want %b", out_vec(), RST_VEC);
        end
        bring_up();
        n_checks++;
        if (ev_zqcl != 51 || ev_ready != 52 + T_ZQINIT + 1 || bus.ref_pending !== 4'd0) begin
            n_fails++;
            $display("FAIL reinit: got zqcl=%0d ready=%0d pend=%0d want 51 %0d 0", ev_zqcl, ev_ready,
                     bus.ref_pending, 52 + T_ZQINIT + 1);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_opp_refresh();
        test_postpone_overrun();
        test_zqcs_interleave();
        test_reset_mid_ref();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
